elastic_pipeline: RTL
=====================

Name: elastic_pipeline

Overview:
Parametrised multi-stage successor to the single-register elastic pipe. It chains depth_p elastic stages. Each stage has a main register and a skid register, so every stage's ready is driven directly from a flop, with no combinational path from yumi_i to ready_o. It sustains one transfer per cycle at any depth. It adds a synchronous flush and an occupancy count, and sits between valid/ready producers and yumi-style consumers wherever long routes need retiming.

Parameters:
width_p, 10, payload width in bits (>=1)
depth_p, 3, number of elastic stages (>=1); total capacity is 2*depth_p entries
count_width_lp, $clog2(2*depth_p+1), derived local parameter giving the width of count_o

Ports:
clk_i  input  1  clock; all state updates on posedge
reset_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of all stages
data_i  input  width_p  upstream payload
valid_i  input  1  upstream valid
ready_o  output  1  upstream ready; registered (stage 0 skid empty)
valid_o  output  1  downstream valid (last stage main valid)
data_o  output  width_p  downstream payload (last stage main register)
yumi_i  input  1  downstream consume; legal only when valid_o=1
count_o  output  count_width_lp  number of entries currently held

Behaviour:
- Reset (reset_ni=0, async):
  - all main/skid valid bits clear; all data registers 0
  - outputs: valid_o=0, data_o=0, ready_o=1, count_o=0
- Upstream transfer: in_fire = valid_i & ready_o.
- Downstream transfer: out_fire = yumi_i & valid_o.
  - yumi_i with valid_o=0 is ignored.
  - Simulation assertion flags this case.
- Per-stage states: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
  - Stage ready_out = ~skid_valid (flopped).
  - Stage accept = next stage's ready, or yumi_i for the last stage.
- EMPTY:
  - in -> ONE, main<=data
  - else stay EMPTY
- ONE:
  - in & accept -> ONE, main<=data
  - in & !accept -> FULL, skid<=data
  - !in & accept -> EMPTY
  - !in & !accept -> stay ONE
- FULL:
  - no input possible (ready=0)
  - accept -> ONE, main<=skid
  - !accept -> hold
- Ordering: strict FIFO; the skid entry is always younger than the main entry.
- Latency: an accepted input appears on data_o/valid_o exactly depth_p cycles later, if no stall.
- Throughput: 1 beat/cycle sustained with yumi_i held high.
- Stall propagation:
  - A downstream stall reaches ready_o only after every stage's skid fills.
  - ready_o drops no earlier than the cycle after stage 0 enters FULL.
- count_o:
  - updates each cycle by +in_fire - out_fire
  - both fires in the same cycle leave it unchanged
  - never exceeds 2*depth_p and never underflows
- Data registers load only on their enable and otherwise hold.
  - data_o is stable while valid_o=1 and yumi_i=0.
- flush_i=1 at posedge:
  - all valid bits clear, count_o -> 0, ready_o -> 1 next cycle
  - a concurrent in_fire beat is discarded
  - a concurrent yumi_i completes the downstream transfer but does not alter the result
  - flush has priority over all other updates; data registers need not clear
- Reset asserted mid-stream: immediate clear regardless of clock; in-flight data is lost.

Optional Feature:
ELASTIC_PIPELINE_STATS_EN
- Defined: adds output stall_cnt_o (32 bits).
  - Increments each cycle with valid_o=1 & yumi_i=0; saturates at 2^32-1.
  - Cleared by reset_ni or flush_i.
  - Adds output full_seen_o, a sticky flag set when count_o reaches 2*depth_p; cleared by reset_ni or flush_i.
- Not defined: neither port exists, and no counter logic is synthesised.
- Core behaviour is identical in both builds.

Test Plan:
- Reset then idle, depth_p=3: valid_o=0, ready_o=1, count_o=0.
- Stream 0x001..0x00A with yumi_i=1, depth_p=3: 0x001 on data_o 3 cycles after its in_fire; one beat per cycle, in order; count_o settles at 3.
- yumi_i=0 while streaming: accepts exactly 6 beats, ready_o=0, count_o=6. Then yumi_i=1: drains 6 beats in order, ready_o returns 1 the cycle after stage 0 skid empties.
- Alternating yumi_i 1/0 with valid_i=1: no loss or duplication; count_o matches the scoreboard every cycle; data_o stable while stalled.
- flush_i with count_o=4 and valid_i=1 in the same cycle: next cycle valid_o=0, count_o=0, ready_o=1; flushed beat never emerges.
- reset_ni pulsed low between clock edges mid-stream: outputs clear immediately; the stream restarts cleanly at the first edge after reset_ni=1.

Source files
------------

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: chain of depth_p elastic stages between a valid/ready
// producer and a yumi-style consumer. Each stage has a main register and a
// skid register, so every stage's ready is a flop output (~skid valid). No
// combinational path exists from yumi_i back to ready_o.
//
// Optional build macro ELASTIC_PIPELINE_STATS_EN adds stall_cnt_o (saturating
// count of cycles with valid_o=1 and yumi_i=0) and full_seen_o (sticky flag
// set once the pipeline holds 2*depth_p entries). Core behaviour is the same
// in both builds.
module elastic_pipeline #(
  parameter  int width_p        = 10,
  parameter  int depth_p        = 3,
  localparam int count_width_lp = $clog2(2*depth_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      flush_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
`ifdef ELASTIC_PIPELINE_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic                      full_seen_o
`endif
);

  localparam int DATA_W = width_p;
  localparam int STAGES = depth_p;
  localparam int CAP    = 2 * depth_p;

  // Occupancy step: +1 on an upstream beat, -1 on a downstream beat, and
  // unchanged when both or neither happen.
  function automatic logic [count_width_lp-1:0] count_step(
    input logic [count_width_lp-1:0] cur,
    input logic                      inc,
    input logic                      dec
  );
    logic [count_width_lp-1:0] nxt;
    nxt = cur;
    if (inc && !dec)      nxt = cur + count_width_lp'(1);
    else if (!inc && dec) nxt = cur - count_width_lp'(1);
    return nxt;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [STAGES-1:0] main_vld;
  logic [STAGES-1:0] skid_vld;
  logic [DATA_W-1:0] main_dat [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              in_vld;
    logic [DATA_W-1:0] in_dat;
    logic              acc;
    logic              main_vld_q;
    logic              skid_vld_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    // ---- stage boundary: input side (upstream port or previous main) ----
    if (s == 0) begin : g_head
      assign in_vld = valid_i;
      assign in_dat = data_i;
    end else begin : g_body
      assign in_vld = main_vld[s-1];
      assign in_dat = main_dat[s-1];
    end

    // ---- stage boundary: output side (next stage ready, or consumer) ----
    if (s == STAGES-1) begin : g_tail
      assign acc = yumi_i;
    end else begin : g_mid
      assign acc = ~skid_vld[s+1];
    end

    // EMPTY/ONE/FULL stage update; skid only ever holds the younger entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
        main_q     <= '0;
        skid_q     <= '0;
      end else if (flush_i) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
      end else if (skid_vld_q) begin
        if (acc) begin
          main_q     <= skid_q;
          skid_vld_q <= 1'b0;
        end
      end else if (main_vld_q) begin
        if (in_vld && acc) begin
          main_q <= in_dat;
        end else if (in_vld) begin
          skid_q     <= in_dat;
          skid_vld_q <= 1'b1;
        end else if (acc) begin
          main_vld_q <= 1'b0;
        end
      end else if (in_vld) begin
        main_q     <= in_dat;
        main_vld_q <= 1'b1;
      end
    end

    assign main_vld[s] = main_vld_q;
    assign skid_vld[s] = skid_vld_q;
    assign main_dat[s] = main_q;
  end

  logic                      in_fire;
  logic                      out_fire;
  logic [count_width_lp-1:0] count_q;

  assign ready_o  = ~skid_vld[0];
  assign valid_o  = main_vld[STAGES-1];
  assign data_o   = main_dat[STAGES-1];
  assign in_fire  = valid_i & ready_o;
  assign out_fire = yumi_i & valid_o;
  assign count_o  = count_q;

  // Occupancy tracks accepted minus consumed beats; flush wins over both.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    count_q <= '0;
    else if (flush_i) count_q <= '0;
    else              count_q <= count_step(count_q, in_fire, out_fire);
  end

`ifdef ELASTIC_PIPELINE_STATS_EN
  logic [31:0] stall_cnt_q;
  logic        full_seen_q;

  // Stall cycles at the output and a sticky "ever completely full" flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt_q <= '0;
      full_seen_q <= 1'b0;
    end else if (flush_i) begin
      stall_cnt_q <= '0;
      full_seen_q <= 1'b0;
    end else begin
      if (valid_o && !yumi_i) stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (count_q == count_width_lp'(CAP)) full_seen_q <= 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign full_seen_o = full_seen_q;
`endif

`ifndef SYNTHESIS
  // A consume with nothing on the output is a consumer protocol error.
  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_ni) yumi_i |-> valid_o
  );
`endif

endmodule
